// File: rtl/fifo_read_arbiter_pkg.sv
// Shared definitions for the decode-stage FIFO read arbiter: requester indices,
// arbitration state encoding and a one-hot to index helper.
package fifo_read_arbiter_pkg;

  localparam int REQ_OPCODE = 0;
  localparam int REQ_MODRM  = 1;
  localparam int REQ_IMMED  = 2;

  localparam int         MAX_REQ         = 8;
  localparam logic [3:0] INSTR_BYTES_MAX = 4'd15;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  function automatic int onehot_idx(input logic [MAX_REQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr_priority_pick.sv
// Combinational one-hot winner select, zero latency, no backpressure.
// FIFO_ARB_ROUND_ROBIN_EN: search starts at i_ptr; otherwise lowest index wins.
module rr_priority_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

`ifdef FIFO_ARB_ROUND_ROBIN_EN
  int w_dist;
  int w_best;

  // Winner is the requester closest to the pointer, walking upward with wrap.
  always_comb begin
    o_gnt  = '0;
    w_dist = 0;
    w_best = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - int'(i_ptr)) % NUM_REQ;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
      end
    end
  end
`else
  logic w_found;
  logic w_unused_ptr;

  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_req[i] && !w_found) begin
        o_gnt[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/fifo_read_arbiter.sv
// Owns the prefetch FIFO read port for one decode consumer at a time; grant one cycle after req,
// no preemption, non-owner strobes are blocked and flagged. FIFO_ARB_ROUND_ROBIN_EN selects round robin.
module fifo_read_arbiter
  import fifo_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               instr_start,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_rd_en,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] req_empty,
  output logic [7:0]         rd_data,
  output logic               fifo_rd_en,
  input  logic [7:0]         fifo_rd_data,
  input  logic               fifo_empty,
  output logic [3:0]         instr_bytes,
  output logic               protocol_err
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [NUM_REQ-1:0] w_pick;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [3:0]         r_bytes;
  logic               r_err;
  logic               w_owner_hold;
  logic               w_stray;
  int                 w_win_idx;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  assign w_owner_hold = |(r_grant & req);
  assign w_stray      = |(req_rd_en & ~r_grant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  // A released owner has req low, so re-picking among req hands off without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    if (flush) begin
      w_state_nxt = IDLE;
      w_grant_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            w_state_nxt = OWNED;
            w_grant_nxt = w_pick;
          end
        end
        OWNED: begin
          if (!w_owner_hold) begin
            w_grant_nxt = w_pick;
            w_state_nxt = (|req) ? OWNED : IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    grant        = r_grant;
    req_empty    = {NUM_REQ{fifo_empty}} | ~r_grant;
    fifo_rd_en   = ~fifo_empty & (|(req_rd_en & r_grant)) & ~flush;
    rd_data      = fifo_rd_data;
    instr_bytes  = r_bytes;
    protocol_err = r_err;
  end

  // Pointer names the requester that gets first look next time: one past the latest owner.
  always_comb begin
    w_win_idx = onehot_idx(MAX_REQ'(w_grant_nxt));
    w_ptr_nxt = (w_win_idx + 1 >= NUM_REQ) ? '0 : PTR_W'(w_win_idx + 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (|w_grant_nxt) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bytes <= '0;
    end else if (flush) begin
      r_bytes <= '0;
    end else if (fifo_rd_en) begin
      if (instr_start) begin
        r_bytes <= 4'd1;
      end else if (r_bytes != INSTR_BYTES_MAX) begin
        r_bytes <= r_bytes + 4'd1;
      end
    end else if (instr_start) begin
      r_bytes <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_stray) begin
      r_err <= 1'b1;
    end
  end

endmodule
